// File: rtl/mo_linebuf_sched.sv
// -----------------------------------------------------------------------------
// mo_linebuf_sched
//   Per-scanline scheduler for the motion-object line buffers A/B. Each line it
//   walks every MO RAM slot once, fetching the descriptor. For each descriptor
//   that hits the current line, it pulses the render-side address load and then
//   holds the render-side chip select for one pixel burst. On every LINE_STB the
//   buffers swap roles. The display-side buffer is read out and cleared
//   continuously.
//
//   Optional feature: define MO_SLOT_LIMIT_EN to cap the number of matched
//   objects per line at MAX_PER_LINE. When the cap is reached, the rest of the
//   line's slots are skipped.
//
// Ports
//   MCKR      in   master clock (rising edge)
//   RESET_b   in   asynchronous active-low reset
//   LINE_STB  in   1-clk pulse at HBLANK start: swap buffers, restart scan
//   BUFCLR_b  in   low = clear the display-side location being read
//   MOACK     in   MO RAM has the descriptor on its data bus
//   MATCH_b   in   low = current descriptor hits this line (valid in MATCH)
//   MOREQ     out  descriptor fetch request
//   MOADDR    out  slot being fetched
//   PADB      out  0: A renders / B displays; 1: B renders / A displays
//   LDA_b     out  1-clk load of the A address counters
//   LDB_b     out  1-clk load of the B address counters
//   ACS_b     out  A RAM chip select
//   BCS_b     out  B RAM chip select
//   CLRA_b    out  A clear enable
//   CLRB_b    out  B clear enable
//   LINE_DONE out  all slots processed for this line
//   OVERRUN   out  LINE_STB arrived before the scan finished (held one line)
// -----------------------------------------------------------------------------
module mo_linebuf_sched #(
  parameter int NSLOTS       = 64,
  parameter int SLOT_W       = 6,
  parameter int OBJ_PIX      = 16,
  parameter int MAX_PER_LINE = 8
) (
  input  logic              MCKR,
  input  logic              RESET_b,
  input  logic              LINE_STB,
  input  logic              BUFCLR_b,
  input  logic              MOACK,
  input  logic              MATCH_b,
  output logic              MOREQ,
  output logic [SLOT_W-1:0] MOADDR,
  output logic              PADB,
  output logic              LDA_b,
  output logic              LDB_b,
  output logic              ACS_b,
  output logic              BCS_b,
  output logic              CLRA_b,
  output logic              CLRB_b,
  output logic              LINE_DONE,
  output logic              OVERRUN
);

  localparam int PIX_W = $clog2(OBJ_PIX + 1);
  localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(OBJ_PIX - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NSLOTS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_MATCH,
    S_LOAD,
    S_WRITE,
    S_NEXT,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [SLOT_W-1:0] r_slot;
  logic [SLOT_W-1:0] w_slot_nxt;
  logic [PIX_W-1:0]  r_pix;
  logic [PIX_W-1:0]  w_pix_nxt;
  logic              r_padb;
  logic              r_run;
  logic              r_overrun;
  logic              w_limit_hit;

`ifdef MO_SLOT_LIMIT_EN
  localparam int CNT_W = $clog2(MAX_PER_LINE + 1);
  logic [CNT_W-1:0] r_objcnt;

  // Matched objects this line; counted as each LOAD is issued.
  always_ff @(posedge MCKR or negedge RESET_b) begin
    if (!RESET_b) begin
      r_objcnt <= '0;
    end else if (LINE_STB) begin
      r_objcnt <= '0;
    end else if (r_state == S_LOAD) begin
      r_objcnt <= r_objcnt + 1'b1;
    end
  end

  assign w_limit_hit = (r_objcnt >= CNT_W'(MAX_PER_LINE));
`else
  assign w_limit_hit = 1'b0;
`endif

  always_ff @(posedge MCKR or negedge RESET_b) begin
    if (!RESET_b) begin
      r_state   <= S_IDLE;
      r_slot    <= '0;
      r_pix     <= '0;
      r_padb    <= 1'b0;
      r_run     <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_slot  <= w_slot_nxt;
      r_pix   <= w_pix_nxt;
      if (LINE_STB) begin
        r_padb    <= ~r_padb;
        r_run     <= 1'b1;
        // A strobe that finds the scan still busy means the line was cut short.
        r_overrun <= !((r_state == S_IDLE) || (r_state == S_DONE));
      end
    end
  end

  // LINE_STB overrides everything, including an MOACK in the same clock.
  always_comb begin
    w_state_nxt = r_state;
    w_slot_nxt  = r_slot;
    w_pix_nxt   = r_pix;
    if (LINE_STB) begin
      w_state_nxt = S_FETCH;
      w_slot_nxt  = '0;
      w_pix_nxt   = '0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (MOACK) w_state_nxt = S_MATCH;
        end
        S_MATCH: begin
          w_state_nxt = MATCH_b ? S_NEXT : S_LOAD;
        end
        S_LOAD: begin
          w_state_nxt = S_WRITE;
          w_pix_nxt   = '0;
        end
        S_WRITE: begin
          if (r_pix == PIX_LAST) begin
            w_state_nxt = S_NEXT;
            w_pix_nxt   = '0;
          end else begin
            w_pix_nxt = r_pix + 1'b1;
          end
        end
        S_NEXT: begin
          // The slot counter stops at the last slot; it never wraps mid-line.
          if ((r_slot == SLOT_LAST) || w_limit_hit) begin
            w_state_nxt = S_DONE;
          end else begin
            w_slot_nxt  = r_slot + 1'b1;
            w_state_nxt = S_FETCH;
          end
        end
        S_IDLE:  w_state_nxt = S_IDLE;
        S_DONE:  w_state_nxt = S_DONE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  logic w_render_ld;
  logic w_render_cs;

  assign w_render_ld = (r_state == S_LOAD);
  assign w_render_cs = (r_state == S_WRITE);

  // The render side is the buffer selected by PADB (A when 0, B when 1).
  // The other buffer is the display side. Until the first LINE_STB after
  // reset, r_run is 0, so the display side stays quiet.
  assign LDA_b  = ~(w_render_ld & ~r_padb);
  assign LDB_b  = ~(w_render_ld &  r_padb);
  assign ACS_b  = ~((w_render_cs & ~r_padb) | (r_run &  r_padb));
  assign BCS_b  = ~((w_render_cs &  r_padb) | (r_run & ~r_padb));
  assign CLRA_b = (r_run &  r_padb) ? BUFCLR_b : 1'b1;
  assign CLRB_b = (r_run & ~r_padb) ? BUFCLR_b : 1'b1;

  assign MOREQ     = (r_state == S_FETCH);
  assign MOADDR    = r_slot;
  assign PADB      = r_padb;
  assign LINE_DONE = (r_state == S_DONE);
  assign OVERRUN   = r_overrun;

endmodule

// File: tb/tb_mo_linebuf_sched.sv
module tb_mo_linebuf_sched;

  localparam int NS    = 64;
  localparam int OP    = 16;
  localparam int MAXPL = 8;
  localparam int BUDGET = 4000;

  logic       MCKR = 1'b0;
  logic       RESET_b, LINE_STB, BUFCLR_b, MOACK, MATCH_b;
  logic       MOREQ, PADB, LDA_b, LDB_b, ACS_b, BCS_b, CLRA_b, CLRB_b;
  logic       LINE_DONE, OVERRUN;
  logic [5:0] MOADDR;

  mo_linebuf_sched #(.NSLOTS(NS), .SLOT_W(6), .OBJ_PIX(OP), .MAX_PER_LINE(MAXPL)) dut (
    .MCKR(MCKR), .RESET_b(RESET_b), .LINE_STB(LINE_STB), .BUFCLR_b(BUFCLR_b),
    .MOACK(MOACK), .MATCH_b(MATCH_b), .MOREQ(MOREQ), .MOADDR(MOADDR), .PADB(PADB),
    .LDA_b(LDA_b), .LDB_b(LDB_b), .ACS_b(ACS_b), .BCS_b(BCS_b), .CLRA_b(CLRA_b),
    .CLRB_b(CLRB_b), .LINE_DONE(LINE_DONE), .OVERRUN(OVERRUN)
  );

  always #5 MCKR = ~MCKR;

  // Object RAM model: which slots hit this line, and the ack responder.
  logic [NS-1:0] match_vec = '0;
  assign MATCH_b = ~match_vec[MOADDR];

  int   ack_mode = 0;  // <0: random 0..2 extra wait clocks per fetch
  logic auto_en = 1'b1;
  logic man_ack = 1'b0;
  logic r_auto_ack = 1'b0;
  int   req_cnt = 0;
  int   cur_dly = 0;
  int   dly_q[$];
  assign MOACK = auto_en ? r_auto_ack : man_ack;

  always @(negedge MCKR) begin
    if (MOREQ) begin
      if (req_cnt == 0) cur_dly = (ack_mode < 0) ? int'($urandom_range(0, 2)) : ack_mode;
      if (req_cnt == cur_dly) dly_q.push_back(cur_dly);
      r_auto_ack = (req_cnt >= cur_dly);
      req_cnt++;
    end else begin
      req_cnt = 0;
      r_auto_ack = 1'b0;
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(string name, integer act, integer exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Observations gathered over one line.
  int   got_fetch[$];
  int   got_ld[$];
  int   got_burst[$];
  int   disp_err, clr_err, both_err, cyc;
  logic timed_out;
  logic exp_padb = 1'b0;

  task automatic run_line();
    logic prev_req;
    logic rcs, dcs, rclr, dclr, rld, dld;
    int   burst;
    got_fetch.delete(); got_ld.delete(); got_burst.delete(); dly_q.delete();
    disp_err = 0; clr_err = 0; both_err = 0; cyc = 0; timed_out = 1'b1;
    @(negedge MCKR);
    LINE_STB = 1'b1;
    @(negedge MCKR);
    LINE_STB = 1'b0;
    exp_padb = ~exp_padb;
    prev_req = 1'b0;
    burst = 0;
    for (int n = 1; n <= BUDGET; n++) begin
      if (LINE_DONE) begin
        cyc = n - 1;
        timed_out = 1'b0;
        break;
      end
      if (MOREQ && !prev_req) got_fetch.push_back(int'(MOADDR));
      prev_req = MOREQ;
      rcs  = PADB ? BCS_b  : ACS_b;
      dcs  = PADB ? ACS_b  : BCS_b;
      rclr = PADB ? CLRB_b : CLRA_b;
      dclr = PADB ? CLRA_b : CLRB_b;
      rld  = PADB ? LDB_b  : LDA_b;
      dld  = PADB ? LDA_b  : LDB_b;
      if (dcs !== 1'b0) disp_err++;
      if (dclr !== BUFCLR_b || rclr !== 1'b1) clr_err++;
      if (dld !== 1'b1 || (!CLRA_b && !CLRB_b)) both_err++;
      if (rld === 1'b0) got_ld.push_back(int'(MOADDR));
      if (rcs === 1'b0) burst++;
      else if (burst > 0) begin
        got_burst.push_back(burst);
        burst = 0;
      end
      BUFCLR_b = 1'($urandom);
      @(negedge MCKR);
    end
    if (burst > 0) got_burst.push_back(burst);
  endtask

  // Reference: the slots fetched, the slots loaded and the line length follow
  // directly from the match pattern, the ack waits and the per-object costs.
  task automatic check_line(string tag);
    int ef[$];
    int el[$];
    int n_m = 0;
    int ec = 0;
    int bad;
    for (int s = 0; s < NS; s++) begin
      ef.push_back(s);
      if (match_vec[s]) begin
        el.push_back(s);
        n_m++;
      end
`ifdef MO_SLOT_LIMIT_EN
      if (n_m == MAXPL) break;
`endif
    end
    for (int i = 0; i < ef.size(); i++) begin
      int d;
      d = (i < dly_q.size()) ? dly_q[i] : 0;
      ec += (d + 1) + (match_vec[ef[i]] ? (3 + OP) : 2);
    end
    chk({tag, ".timeout"}, timed_out, 0);
    chk({tag, ".cycles"}, cyc, ec);
    chk({tag, ".acks"}, dly_q.size(), ef.size());
    chk({tag, ".fetch_n"}, got_fetch.size(), ef.size());
    bad = -1;
    for (int i = 0; i < ef.size() && i < got_fetch.size(); i++)
      if (got_fetch[i] != ef[i] && bad < 0) bad = i;
    chk({tag, ".fetch_bad_idx"}, bad, -1);
    chk({tag, ".load_n"}, got_ld.size(), el.size());
    bad = -1;
    for (int i = 0; i < el.size() && i < got_ld.size(); i++)
      if (got_ld[i] != el[i] && bad < 0) bad = i;
    chk({tag, ".load_bad_idx"}, bad, -1);
    chk({tag, ".burst_n"}, got_burst.size(), el.size());
    bad = -1;
    for (int i = 0; i < got_burst.size(); i++)
      if (got_burst[i] != OP && bad < 0) bad = i;
    chk({tag, ".burst_len_bad_idx"}, bad, -1);
    chk({tag, ".display_cs_errs"}, disp_err, 0);
    chk({tag, ".clr_errs"}, clr_err, 0);
    chk({tag, ".both_side_errs"}, both_err, 0);
    chk({tag, ".padb"}, PADB, exp_padb);
    chk({tag, ".overrun"}, OVERRUN, 0);
    chk({tag, ".moreq_at_done"}, MOREQ, 0);
  endtask

  task automatic wait_done(string tag);
    for (int i = 0; i < BUDGET; i++) begin
      if (LINE_DONE) break;
      @(negedge MCKR);
    end
    chk({tag, ".line_done"}, LINE_DONE, 1);
  endtask

  task automatic wait_render_cs(string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < BUDGET; i++) begin
      if ((PADB ? BCS_b : ACS_b) == 1'b0) begin
        found = 1'b1;
        break;
      end
      @(negedge MCKR);
    end
    chk({tag, ".reach_write"}, found, 1);
  endtask

  typedef struct {
    int kind;     // 0 none, 1 slot 5 only, 2 all slots, 3 slots 0 and 63
    int dly;      // extra ack wait clocks
    int exp_cyc;  // clocks from LINE_STB to LINE_DONE
    int exp_ld;   // number of LOAD pulses
  } vec_t;

  initial begin
    vec_t vecs[6];
    logic found;

    vecs[0] = '{0, 0, 192, 0};
    vecs[1] = '{1, 0, 209, 1};
    vecs[2] = '{0, 1, 256, 0};
    vecs[3] = '{3, 0, 226, 2};
`ifdef MO_SLOT_LIMIT_EN
    vecs[4] = '{2, 0, 160, 8};
`else
    vecs[4] = '{2, 0, 1280, 64};
`endif
    vecs[5] = '{1, 2, 337, 1};

    RESET_b  = 1'b1;
    LINE_STB = 1'b0;
    BUFCLR_b = 1'b1;
    #1 RESET_b = 1'b0;
    repeat (3) @(negedge MCKR);
    chk("reset.moreq", MOREQ, 0);
    chk("reset.moaddr", MOADDR, 0);
    chk("reset.padb", PADB, 0);
    chk("reset.line_done", LINE_DONE, 0);
    chk("reset.overrun", OVERRUN, 0);
    chk("reset.strobes_b", {LDA_b, LDB_b, ACS_b, BCS_b, CLRA_b, CLRB_b}, 6'h3f);
    RESET_b = 1'b1;
    repeat (3) @(negedge MCKR);
    chk("idle.moreq", MOREQ, 0);
    chk("idle.strobes_b", {LDA_b, LDB_b, ACS_b, BCS_b, CLRA_b, CLRB_b}, 6'h3f);

    for (int v = 0; v < 6; v++) begin
      match_vec = '0;
      case (vecs[v].kind)
        1: match_vec[5] = 1'b1;
        2: match_vec = '1;
        3: begin match_vec[0] = 1'b1; match_vec[63] = 1'b1; end
        default: match_vec = '0;
      endcase
      ack_mode = vecs[v].dly;
      run_line();
      chk($sformatf("vec%0d.cycles", v), cyc, vecs[v].exp_cyc);
      chk($sformatf("vec%0d.loads", v), got_ld.size(), vecs[v].exp_ld);
      check_line($sformatf("vec%0d", v));
    end

    // Strobe arrives mid-burst on slot 10.
    match_vec = '0;
    match_vec[10] = 1'b1;
    ack_mode = 0;
    @(negedge MCKR); LINE_STB = 1'b1;
    @(negedge MCKR); LINE_STB = 1'b0;
    exp_padb = ~exp_padb;
    wait_render_cs("ovr");
    chk("ovr.slot_at_write", MOADDR, 10);
    LINE_STB = 1'b1;
    @(negedge MCKR); LINE_STB = 1'b0;
    exp_padb = ~exp_padb;
    chk("ovr.padb", PADB, exp_padb);
    chk("ovr.overrun", OVERRUN, 1);
    chk("ovr.moaddr", MOADDR, 0);
    chk("ovr.moreq", MOREQ, 1);
    chk("ovr.render_cs_off", PADB ? BCS_b : ACS_b, 1);
    wait_done("ovr");
    chk("ovr.overrun_held", OVERRUN, 1);
    run_line();
    check_line("ovr_next");

    // Strobe and ack in the same clock while fetching slot 3.
    match_vec = '0;
    auto_en = 1'b0;
    man_ack = 1'b0;
    @(negedge MCKR); LINE_STB = 1'b1;
    @(negedge MCKR); LINE_STB = 1'b0;
    exp_padb = ~exp_padb;
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (MOREQ && MOADDR == 6'd3) begin
        found = 1'b1;
        break;
      end
      man_ack = MOREQ;
      @(negedge MCKR);
    end
    chk("race.reach_slot3", found, 1);
    LINE_STB = 1'b1;
    man_ack  = 1'b1;
    @(negedge MCKR);
    LINE_STB = 1'b0;
    man_ack  = 1'b0;
    exp_padb = ~exp_padb;
    chk("race.moreq", MOREQ, 1);
    chk("race.moaddr", MOADDR, 0);
    chk("race.padb", PADB, exp_padb);
    chk("race.overrun", OVERRUN, 1);
    @(negedge MCKR);
    chk("race.still_fetch", MOREQ, 1);
    chk("race.moaddr_held", MOADDR, 0);
    auto_en = 1'b1;
    wait_done("race");

    // Reset pulse in the middle of a burst.
    match_vec = '0;
    match_vec[2] = 1'b1;
    @(negedge MCKR); LINE_STB = 1'b1;
    @(negedge MCKR); LINE_STB = 1'b0;
    exp_padb = ~exp_padb;
    wait_render_cs("rst");
    #2 RESET_b = 1'b0;
    #1;
    chk("rst.async_strobes_b", {LDA_b, LDB_b, ACS_b, BCS_b, CLRA_b, CLRB_b}, 6'h3f);
    chk("rst.async_moreq", MOREQ, 0);
    chk("rst.async_padb", PADB, 0);
    chk("rst.async_overrun", OVERRUN, 0);
    @(negedge MCKR);
    @(negedge MCKR);
    RESET_b = 1'b1;
    exp_padb = 1'b0;
    repeat (5) @(negedge MCKR);
    chk("rst.idle_moreq", MOREQ, 0);
    chk("rst.idle_done", LINE_DONE, 0);
    chk("rst.idle_cs", {ACS_b, BCS_b}, 2'b11);
    run_line();
    check_line("rst_recover");

    // Random match patterns and ack waits.
    ack_mode = -1;
    for (int r = 0; r < 6; r++) begin
      match_vec = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
      run_line();
      check_line($sformatf("rand%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
